// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared defaults and FSM encoding for the Sobel window front-end
package sobel_pkg;

    localparam int IMG_W_DEF = 256;
    localparam int IMG_H_DEF = 256;
    localparam int DW_DEF    = 8;
    localparam int CW_DEF    = 10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Address width for a line buffer; a single-entry buffer still needs one bit.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sobel_window_ctrl_if.sv
// rtl/sobel_window_ctrl_if.sv - raster pixel stream between image source and window sequencer
interface sobel_window_ctrl_if #(
    parameter int DW = 8
) ();

    logic [DW-1:0] pix;
    logic          pix_valid;
    logic          pix_ready;

    modport master (
        output pix,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix,
        input  pix_valid,
        output pix_ready
    );

endinterface

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - one image line of pixel storage
// Read is combinational so the old entry is visible in the same cycle it is overwritten.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = addr_bits(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/sobel_window_ctrl.sv
// rtl/sobel_window_ctrl.sv - raster stream to 3x3 window sequencer feeding the Sobel core
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int DW    = DW_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    sobel_window_ctrl_if.slave   pix_if,
    output logic [DW-1:0]        data_0_0_o,
    output logic [DW-1:0]        data_0_1_o,
    output logic [DW-1:0]        data_0_2_o,
    output logic [DW-1:0]        data_1_0_o,
    output logic [DW-1:0]        data_1_1_o,
    output logic [DW-1:0]        data_1_2_o,
    output logic [DW-1:0]        data_2_0_o,
    output logic [DW-1:0]        data_2_1_o,
    output logic [DW-1:0]        data_2_2_o,
    output logic                 core_en_o,
    output logic [CW-1:0]        cnt_col_o,
    output logic [CW-1:0]        cnt_row_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int            AW       = addr_bits(IMG_W);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
    localparam logic [CW-1:0] TWO      = CW'(2);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef logic [DW-1:0] win_arr_t [3][3];

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    win_arr_t      win_q, win_d;
    win_arr_t      out_q;
    logic          core_en_q;
    logic [CW-1:0] cnt_col_q, cnt_row_q;

    logic          accept;
    logic          last_beat;
    logic          win_ok;
    logic [DW-1:0] lb0_rd, lb1_rd;

    assign pix_if.pix_ready = (state_q == ST_RUN);
    assign accept    = (state_q == ST_RUN) && pix_if.pix_valid;
    assign last_beat = accept && (col_q == COL_LAST) && (row_q == ROW_LAST);
    // Wrap-around columns 0/1 carry previous-line taps, so they never form a window.
    assign win_ok    = accept && (row_q >= TWO) && (col_q >= TWO);

    sobel_line_buffer #(
        .DEPTH (IMG_W),
        .DW    (DW),
        .AW    (AW)
    ) u_lb0 (
        .clk     (clk),
        .addr_i  (col_q[AW-1:0]),
        .we_i    (accept),
        .wdata_i (pix_if.pix),
        .rdata_o (lb0_rd)
    );

    sobel_line_buffer #(
        .DEPTH (IMG_W),
        .DW    (DW),
        .AW    (AW)
    ) u_lb1 (
        .clk     (clk),
        .addr_i  (col_q[AW-1:0]),
        .we_i    (accept),
        .wdata_i (lb0_rd),
        .rdata_o (lb1_rd)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_RUN: begin
                if (last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = pix_if.pix;

            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ONE;
            end else begin
                col_d = col_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            core_en_q <= 1'b0;
            cnt_col_q <= '0;
            cnt_row_q <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                    out_q[r][c] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            win_q     <= win_d;
            core_en_q <= win_ok;
            // win_ok guarantees col/row >= 2, so the centre coordinates cannot underflow.
            if (win_ok) begin
                out_q     <= win_d;
                cnt_col_q <= col_q - ONE;
                cnt_row_q <= row_q - ONE;
            end
        end
    end

    assign data_0_0_o = out_q[0][0];
    assign data_0_1_o = out_q[0][1];
    assign data_0_2_o = out_q[0][2];
    assign data_1_0_o = out_q[1][0];
    assign data_1_1_o = out_q[1][1];
    assign data_1_2_o = out_q[1][2];
    assign data_2_0_o = out_q[2][0];
    assign data_2_1_o = out_q[2][1];
    assign data_2_2_o = out_q[2][2];

    assign core_en_o = core_en_q;
    assign cnt_col_o = cnt_col_q;
    assign cnt_row_o = cnt_row_q;
    assign busy_o    = (state_q == ST_RUN);
    assign done_o    = (state_q == ST_DONE);

endmodule
